// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared bus widths and response-owner encoding for the core/memory arbiter
package riscv_bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: IF/LS requester ports plus the single-port memory port
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = riscv_bus_pkg::ADDR_W,
  parameter int DATA_W = riscv_bus_pkg::DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic                ls_req;
  logic                ls_we;
  logic [ADDR_W-1:0]   ls_addr;
  logic [DATA_W-1:0]   ls_wdata;
  logic [DATA_W/8-1:0] ls_be;
  logic                ls_gnt;
  logic                ls_rvalid;
  logic [DATA_W-1:0]   ls_rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_rdata;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: counts consecutive denied IF cycles and raises force_if once MAX_WAIT is reached
module arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);
  logic [3:0] cnt;
  assign force_if = cnt >= 4'(MAX_WAIT);
  always_ff @(posedge clk)
    cnt <= (rst || !if_req || if_gnt) ? '0 : force_if ? cnt : cnt + 4'd1;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one synchronous memory between IF and LS, LS-priority with bounded IF starvation
module mem_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.slave bus
);
  owner_t own_q, own_d;
  logic force_if;
  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req   (bus.if_req),
    .if_gnt   (bus.if_gnt),
    .force_if (force_if)
  );
  assign bus.if_gnt = !rst && bus.if_req && (!bus.ls_req || force_if);
  assign bus.ls_gnt = !rst && bus.ls_req && !(bus.if_req && force_if);
  assign bus.mem_en    = bus.if_gnt || bus.ls_gnt;
  assign bus.mem_we    = bus.ls_gnt && bus.ls_we;
  assign bus.mem_addr  = bus.if_gnt ? bus.if_addr : bus.ls_addr;
  assign bus.mem_wdata = bus.ls_wdata;
  assign bus.mem_be    = bus.mem_we ? bus.ls_be : bus.mem_en ? '1 : '0;
  always_ff @(posedge clk)
    own_q <= rst ? OWN_NONE : own_d;
  always_comb begin
    own_d = OWN_NONE;
    if (bus.if_gnt) own_d = OWN_IF;
    else if (bus.ls_gnt && !bus.ls_we) own_d = OWN_LS;
  end
  // Gating with rst drops a response whose grant preceded a reset
  assign bus.if_rvalid = !rst && own_q == OWN_IF;
  assign bus.ls_rvalid = !rst && own_q == OWN_LS;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter/memory model
module tb_mem_bus_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  mem_bus_arbiter_if bus ();
  mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial for (int i = 0; i < 256; i++) mem[i] = (i < 64) ? (32'hA500_0000 | 32'(i)) : 32'h0;
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b+:8] = bus.mem_wdata[8*b+:8];
      end else bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.if_rvalid, bus.ls_rvalid} !== 5'b0) begin
        errors++;
        $display("FAIL reset cyc%0d gnt/en/rvalid got %b want 00000", i,
                 {bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.if_rvalid, bus.ls_rvalid});
      end
    end
    rst = 1'b0; bus.if_req = 1'b0; bus.ls_req = 1'b0;
    tick();
  endtask
  task automatic test_if_only;
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    #1;
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.mem_we, bus.mem_be} !== 8'b1010_1111 || bus.mem_addr !== 32'h80) begin
      errors++;
      $display("FAIL if_only_grant gnt/en/we/be got %b addr %h want 10101111 addr 00000080",
               {bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.mem_we, bus.mem_be}, bus.mem_addr);
    end
    tick();
    bus.if_req = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid} !== 2'b10 || bus.if_rdata !== 32'hA500_0020) begin
      errors++;
      $display("FAIL if_only_resp rvalid got %b data %h want 10 data a5000020",
               {bus.if_rvalid, bus.ls_rvalid}, bus.if_rdata);
    end
    tick();
  endtask
  task automatic test_ls_write_read;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h100;
    bus.ls_wdata = 32'hDEAD_BEEF; bus.ls_be = 4'b0011;
    #1;
    checks++;
    if ({bus.ls_gnt, bus.if_gnt, bus.mem_en, bus.mem_we} !== 4'b1011 || bus.mem_be !== 4'b0011 ||
        bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL ls_write gnt/en/we got %b be %b wdata %h addr %h want 1011 0011 deadbeef 00000100",
               {bus.ls_gnt, bus.if_gnt, bus.mem_en, bus.mem_we}, bus.mem_be, bus.mem_wdata, bus.mem_addr);
    end
    tick();
    bus.ls_we = 1'b0; bus.ls_be = 4'b0000;
    #1;
    checks++;
    if ({bus.ls_gnt, bus.mem_we, bus.mem_be, bus.ls_rvalid} !== 7'b1011110) begin
      errors++;
      $display("FAIL ls_read_after_write gnt/we/be/rvalid got %b want 1011110",
               {bus.ls_gnt, bus.mem_we, bus.mem_be, bus.ls_rvalid});
    end
    tick();
    bus.ls_req = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid} !== 2'b01 || bus.ls_rdata !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL ls_read_resp rvalid got %b data %h want 01 data 0000beef",
               {bus.if_rvalid, bus.ls_rvalid}, bus.ls_rdata);
    end
    tick();
    checks++;
    if (bus.ls_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL ls_idle_rvalid got %b want 0", bus.ls_rvalid);
    end
  endtask
  task automatic test_contention;
    logic [1:0] prev = 2'b00;
    int wait_run = 0;
    int wait_max = 0;
    bit exp_if;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h44;
    for (int i = 0; i < 15; i++) begin
      #1;
      exp_if = (i % (MAX_WAIT + 1)) == MAX_WAIT;
      checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== {exp_if, !exp_if}) begin
        errors++;
        $display("FAIL contention_gnt cyc%0d if/ls got %b want %b", i, {bus.if_gnt, bus.ls_gnt}, {exp_if, !exp_if});
      end
      checks++;
      if ({bus.if_rvalid, bus.ls_rvalid} !== prev) begin
        errors++;
        $display("FAIL contention_rvalid cyc%0d if/ls got %b want %b", i, {bus.if_rvalid, bus.ls_rvalid}, prev);
      end
      wait_run = bus.if_gnt ? 0 : wait_run + 1;
      wait_max = wait_run > wait_max ? wait_run : wait_max;
      prev = {exp_if, !exp_if};
      tick();
    end
    checks++;
    if (wait_max > MAX_WAIT || wait_max < MAX_WAIT) begin
      errors++;
      $display("FAIL contention_max_wait got %0d want %0d", wait_max, MAX_WAIT);
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    tick();
  endtask
  task automatic test_back_to_back;
    bus.if_req = 1'b1; bus.if_addr = 32'h84;
    #1;
    checks++;
    if ({bus.if_gnt, bus.ls_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_if_gnt got %b want 10", {bus.if_gnt, bus.ls_gnt});
    end
    tick();
    bus.if_req = 1'b0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h100;
    #1;
    checks++;
    if ({bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid} !== 3'b110 || bus.if_rdata !== 32'hA500_0021) begin
      errors++;
      $display("FAIL b2b_if_resp gnt/rvalids got %b data %h want 110 data a5000021",
               {bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid}, bus.if_rdata);
    end
    tick();
    bus.ls_req = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid} !== 2'b01 || bus.ls_rdata !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL b2b_ls_resp rvalids got %b data %h want 01 data 0000beef",
               {bus.if_rvalid, bus.ls_rvalid}, bus.ls_rdata);
    end
    tick();
  endtask
  task automatic test_reset_mid;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h88;
    #1;
    checks++;
    if (bus.ls_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt got %b want 1", bus.ls_gnt);
    end
    tick();
    bus.ls_req = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_during rvalids got %b want 00", {bus.if_rvalid, bus.ls_rvalid});
    end
    tick();
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h88;
    #1;
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid, bus.if_gnt} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_after rvalids/if_gnt got %b want 001", {bus.if_rvalid, bus.ls_rvalid, bus.if_gnt});
    end
    tick();
    bus.if_req = 1'b0;
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA500_0022) begin
      errors++;
      $display("FAIL rstmid_resume rvalid %b data %h want 1 data a5000022", bus.if_rvalid, bus.if_rdata);
    end
    tick();
  endtask
  task automatic test_random;
    int waited = 0;
    bit p_if = 0, p_ls = 0, g_if = 1, g_ls = 1, exp_if, exp_ls;
    logic [31:0] p_data = '0;
    logic [31:0] exp_addr;
    logic [3:0] exp_be;
    logic [7:0] idx;
    for (int i = 128; i < 256; i++) ref_mem[i] = '0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.if_req || g_if) begin
        bus.if_req = ($urandom % 3) != 0;
        bus.if_addr = {22'd0, 8'($urandom_range(128, 255)), 2'b00};
      end
      if (!bus.ls_req || g_ls) begin
        bus.ls_req = ($urandom % 3) != 0;
        bus.ls_we = $urandom % 2;
        bus.ls_addr = {22'd0, 8'($urandom_range(128, 255)), 2'b00};
        bus.ls_wdata = $urandom;
        bus.ls_be = 4'($urandom);
      end
      #1;
      exp_if = bus.if_req && (!bus.ls_req || waited >= MAX_WAIT);
      exp_ls = bus.ls_req && !exp_if;
      checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== {exp_if, exp_ls}) begin
        errors++;
        $display("FAIL rand_gnt cyc%0d if/ls got %b want %b", c, {bus.if_gnt, bus.ls_gnt}, {exp_if, exp_ls});
      end
      checks++;
      if ({bus.if_rvalid, bus.ls_rvalid} !== {p_if, p_ls}) begin
        errors++;
        $display("FAIL rand_rvalid cyc%0d if/ls got %b want %b", c, {bus.if_rvalid, bus.ls_rvalid}, {p_if, p_ls});
      end
      if (p_if || p_ls) begin
        checks++;
        if ((p_if ? bus.if_rdata : bus.ls_rdata) !== p_data) begin
          errors++;
          $display("FAIL rand_rdata cyc%0d got %h want %h", c, p_if ? bus.if_rdata : bus.ls_rdata, p_data);
        end
      end
      exp_addr = exp_if ? bus.if_addr : bus.ls_addr;
      exp_be = (exp_ls && bus.ls_we) ? bus.ls_be : (exp_if || exp_ls) ? 4'hF : 4'h0;
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_be} !== {exp_if || exp_ls, exp_ls && bus.ls_we, exp_be} ||
          ((exp_if || exp_ls) && bus.mem_addr !== exp_addr) ||
          (exp_ls && bus.ls_we && bus.mem_wdata !== bus.ls_wdata)) begin
        errors++;
        $display("FAIL rand_mem cyc%0d en/we/be %b addr %h want %b addr %h", c,
                 {bus.mem_en, bus.mem_we, bus.mem_be}, bus.mem_addr,
                 {exp_if || exp_ls, exp_ls && bus.ls_we, exp_be}, exp_addr);
      end
      idx = exp_addr[9:2];
      p_if = exp_if;
      p_ls = exp_ls && !bus.ls_we;
      p_data = ref_mem[idx];
      if (exp_ls && bus.ls_we)
        for (int b = 0; b < 4; b++) if (bus.ls_be[b]) ref_mem[idx][8*b+:8] = bus.ls_wdata[8*b+:8];
      waited = (bus.if_req && !exp_if) ? waited + 1 : 0;
      g_if = exp_if;
      g_ls = exp_ls;
      tick();
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    tick();
  endtask
  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_be = '0;
    test_reset();
    test_if_only();
    test_ls_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
